// File: rtl/hex_readback.sv
// hex_readback
//   Reads back the digits currently shown on six active-low 7-segment
//   displays. One scan visits HEX0..HEX5 in order. Each slot is held for
//   DWELL cycles and then sampled. The sampled pattern is decoded to a hex
//   digit, together with a flag that says whether it was a legal glyph.
//
// Parameters
//   DWELL         cycles per display slot before sampling (1..255)
// Ports
//   clock         system clock; all state changes on its rising edge
//   reset         synchronous, active-high reset
//   start         request one scan; sampled only in IDLE
//   hex0..hex5    active-low segment patterns, bit0=a .. bit6=g
//   busy          high while scanning
//   done          one-cycle pulse after the last slot is sampled
//   value         decoded digits; value[4i+3:4i] holds the digit of hexi
//   valid         valid[i] is set when hexi matched a legal glyph
//   ledr          status: [3:0] last nibble, [6:4] slot index,
//                 [7] last valid, [8] busy, [9] done
module hex_readback #(
    parameter int DWELL = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [6:0]  hex0,
    input  logic [6:0]  hex1,
    input  logic [6:0]  hex2,
    input  logic [6:0]  hex3,
    input  logic [6:0]  hex4,
    input  logic [6:0]  hex5,
    output logic        busy,
    output logic        done,
    output logic [23:0] value,
    output logic [5:0]  valid,
    output logic [9:0]  ledr
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    logic [1:0] state;
    logic [2:0] index;
    logic [7:0] count;
    logic [3:0] last_nib;
    logic       last_vld;
    logic [6:0] hex_sel;
    logic [4:0] dec;

    // Returns {legal, digit}; unknown patterns decode to {0, 0}.
    function automatic logic [4:0] decode(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'h40:   r = 5'h10;
            7'h79:   r = 5'h11;
            7'h24:   r = 5'h12;
            7'h30:   r = 5'h13;
            7'h19:   r = 5'h14;
            7'h12:   r = 5'h15;
            7'h02:   r = 5'h16;
            7'h78:   r = 5'h17;
            7'h00:   r = 5'h18;
            7'h10:   r = 5'h19;
            7'h08:   r = 5'h1A;
            7'h03:   r = 5'h1B;
            7'h46:   r = 5'h1C;
            7'h21:   r = 5'h1D;
            7'h06:   r = 5'h1E;
            7'h0E:   r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    // Only the display under the current index is looked at. The others are
    // not snapshotted, so each slot sees its display as it is at its own edge.
    always_comb begin
        hex_sel = 7'h7F;
        case (index)
            3'd0:    hex_sel = hex0;
            3'd1:    hex_sel = hex1;
            3'd2:    hex_sel = hex2;
            3'd3:    hex_sel = hex3;
            3'd4:    hex_sel = hex4;
            3'd5:    hex_sel = hex5;
            default: hex_sel = 7'h7F;
        endcase
    end

    assign dec = decode(hex_sel);

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            index    <= 3'd0;
            count    <= 8'd0;
            value    <= 24'd0;
            valid    <= 6'd0;
            last_nib <= 4'd0;
            last_vld <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_SCAN;
                        index <= 3'd0;
                        count <= 8'd0;
                        valid <= 6'd0;
                    end
                end
                S_SCAN: begin
                    if (count == DWELL_LAST) begin
                        count                     <= 8'd0;
                        value[{index, 2'b00} +: 4] <= dec[3:0];
                        valid[index]              <= dec[4];
                        last_nib                  <= dec[3:0];
                        last_vld                  <= dec[4];
                        // The index stays at 5 after the last slot so the
                        // status LEDs keep showing where the scan ended.
                        if (index == 3'd5)
                            state <= S_DONE;
                        else
                            index <= index + 3'd1;
                    end else begin
                        count <= count + 8'd1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // busy and done are decoded straight from the state register. They have
    // no path from start or the hex inputs.
    assign busy = (state == S_SCAN);
    assign done = (state == S_DONE);
    assign ledr = {done, busy, last_vld, index, last_nib};

endmodule

// File: doc/hex_readback.md
HEX_READBACK -- requirements
Module: hex_readback

Interface
REQ-001 Parameter DWELL, default 1, clock cycles spent on each display slot before it is sampled; legal range 1..255.
REQ-002 CLOCK  in  1  system clock; all state updates on its rising edge.
REQ-003 RESET  in  1  synchronous, active-high reset.
REQ-004 START  in  1  request one readback scan; sampled only in IDLE.
REQ-005 HEX0..HEX5  in  7 each  active-low segment patterns; bit0=a .. bit6=g.
REQ-006 BUSY  out  1  high while state is SCAN.
REQ-007 DONE  out  1  one-cycle pulse; scan complete.
REQ-008 VALUE  out  24  decoded digits; VALUE[4i+3:4i] holds the digit of HEXi.
REQ-009 VALID  out  6  VALID[i]=1 when the HEXi pattern matched a legal glyph.
REQ-010 LEDR  out  10  status: [3:0] last decoded nibble, [6:4] slot index, [7] last valid, [8] BUSY, [9] DONE.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, SCAN and DONE.
REQ-012 In IDLE, START=1 at an edge SHALL enter SCAN, set index=0, dwell count=0 and VALID=6'b0; VALUE SHALL be retained.
REQ-013 In SCAN, each edge with count<DWELL-1 SHALL increment the count only.
REQ-014 In SCAN, an edge with count=DWELL-1 SHALL sample HEX[index], write its nibble and valid bit, update LEDR[3:0] and LEDR[7], and clear the count.
REQ-015 After a sample at index<5, the index SHALL increment; after the sample at index=5, the state SHALL go to DONE.
REQ-016 Timing: with START accepted at edge t0, the slot-i samples SHALL occur at edges t0+(i+1)*DWELL.
REQ-017 Timing: DONE SHALL be high for the single cycle following edge t0+6*DWELL, BUSY SHALL be low in that cycle, and the next edge SHALL return the state to IDLE.
REQ-018 Each sample SHALL capture the HEX value present in the cycle before its sampling edge; no snapshot of the other displays is taken.
REQ-019 Decode table (hex pattern -> digit):
- 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7
- 00->8, 10->9, 08->A, 03->b, 46->C, 21->d, 06->E, 0E->F
REQ-020 Any pattern not in the decode table SHALL write nibble 0 with valid bit 0.
REQ-021 START SHALL be ignored in SCAN and DONE; no queuing and no restart.
REQ-022 A START held high continuously SHALL start a new scan on the first edge in IDLE after DONE, so a held START gives back-to-back scans with one IDLE cycle between them.
REQ-023 LEDR[6:4] SHALL show the current index in SCAN and SHALL hold its last value (5 after a full scan) in IDLE and DONE.
REQ-024 VALUE, VALID and LEDR[3:0]/[7] SHALL hold their values between scans.
REQ-025 All outputs SHALL be registered or decoded directly from the state register; there is no combinational path from HEXx or START to any output.

Reset
REQ-026 RESET=1 at an edge SHALL force IDLE, index=0, count=0, VALUE=0, VALID=0, BUSY=0, DONE=0 and LEDR=0, taking precedence over START.
REQ-027 RESET asserted mid-scan SHALL abort the scan with no DONE pulse; a START at the first edge after RESET deasserts SHALL be accepted.

Verification
REQ-028 DWELL=1, HEX5..HEX0 = 0E,06,21,46,03,08, START pulse -> BUSY for 6 cycles, DONE pulse in cycle 7, VALUE=24'hFEDCBA, VALID=6'h3F.
REQ-029 DWELL=4, HEX0=79, HEX3=7F (blank), all other displays 40 -> samples at t0+4, 8, .. 24; VALUE=24'h000001, VALID=6'b110111, DONE in the cycle after edge t0+24.
REQ-030 HEX2 changes 24->30 between edges t0+2 and t0+3 (DWELL=1) -> VALUE[11:8]=3; earlier slots are not disturbed.
REQ-031 RESET asserted at edge t0+3 of a scan -> no DONE pulse, all outputs 0 at the next cycle; a fresh START then completes normally.
REQ-032 START held high for 20 cycles with DWELL=1 -> DONE pulses at cycles 7 and 15, BUSY low in the IDLE cycle between scans, and repeated START during SCAN is ignored.
